// File: rtl/can_bit_stuff.sv
// CAN transmit bit stuffer: inserts a complementary bit after STUFF_LEN
// identical bits inside the stuffed region (SOF..CRC) and stalls the
// serializer for that bit time.
//
// Ports:
//   CLK, RST_N    clock, async active-low reset
//   BIT_TICK      one-CLK strobe per nominal bit time
//   ABORT         synchronous clear, wins over BIT_TICK
//   STUFF_EN      IN_BIT belongs to the stuffed region
//   IN_VALID      serializer has a bit; IN_BIT is the bit
//   IN_READY      bit consumed this cycle (combinational)
//   TX_BIT        registered bit to the CAN TX driver
//   STUFF_ACTIVE  TX_BIT is currently a stuff bit
//   UNDERRUN      one-CLK pulse: tick with no bit inside stuffed region
module can_bit_stuff #(
    parameter int STUFF_LEN = 5
) (
    input  logic CLK,
    input  logic RST_N,
    input  logic BIT_TICK,
    input  logic ABORT,
    input  logic STUFF_EN,
    input  logic IN_VALID,
    input  logic IN_BIT,
    output logic IN_READY,
    output logic TX_BIT,
    output logic STUFF_ACTIVE,
    output logic UNDERRUN
);

    localparam logic [2:0] RUN_MAX = 3'(STUFF_LEN);

    logic       last_bit;
    logic [2:0] run_cnt;
    logic       stuff_pending;
    logic [2:0] run_next;

    // A stuff bit owes the slot, so the serializer is held off.
    assign IN_READY = BIT_TICK & ~stuff_pending & ~ABORT & RST_N;

    // run_cnt==0 means "no run yet", so the first stuffed bit
    // always starts a fresh run even if it matches last_bit.
    always_comb begin
        run_next = 3'd1;
        if (IN_BIT == last_bit && run_cnt != 3'd0)
            run_next = run_cnt + 3'd1;
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            TX_BIT        <= 1'b1;
            STUFF_ACTIVE  <= 1'b0;
            UNDERRUN      <= 1'b0;
            last_bit      <= 1'b1;
            run_cnt       <= 3'd0;
            stuff_pending <= 1'b0;
        end else begin
            UNDERRUN <= 1'b0;
            if (ABORT) begin
                TX_BIT        <= 1'b1;
                STUFF_ACTIVE  <= 1'b0;
                last_bit      <= 1'b1;
                run_cnt       <= 3'd0;
                stuff_pending <= 1'b0;
            end else if (BIT_TICK) begin
                if (stuff_pending) begin
                    // Emitted even if STUFF_EN has dropped, so a
                    // stuff bit after the last CRC bit still goes out.
                    TX_BIT        <= ~last_bit;
                    STUFF_ACTIVE  <= 1'b1;
                    last_bit      <= ~last_bit;
                    run_cnt       <= 3'd1;
                    stuff_pending <= 1'b0;
                end else if (IN_VALID) begin
                    TX_BIT       <= IN_BIT;
                    STUFF_ACTIVE <= 1'b0;
                    last_bit     <= IN_BIT;
                    if (STUFF_EN) begin
                        run_cnt <= run_next;
                        if (run_next == RUN_MAX)
                            stuff_pending <= 1'b1;
                    end else begin
                        run_cnt <= 3'd0;
                    end
                end else begin
                    TX_BIT       <= 1'b1;
                    STUFF_ACTIVE <= 1'b0;
                    run_cnt      <= 3'd0;
                    UNDERRUN     <= STUFF_EN;
                end
            end
        end
    end

endmodule

// File: tb/tb_can_bit_stuff.sv
// Directed vector bench for can_bit_stuff (STUFF_LEN=5).
// Each vector is one bit tick followed by one idle cycle.
module tb_can_bit_stuff;

    logic CLK = 1'b0;
    logic RST_N = 1'b0;
    logic BIT_TICK = 1'b0;
    logic ABORT = 1'b0;
    logic STUFF_EN = 1'b0;
    logic IN_VALID = 1'b0;
    logic IN_BIT = 1'b0;
    logic IN_READY, TX_BIT, STUFF_ACTIVE, UNDERRUN;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic en, vld, bt, ab;
        logic rdy, tx, st, un;
    } vec_t;

    vec_t vt[$];

    can_bit_stuff #(.STUFF_LEN(5)) dut (
        .CLK(CLK), .RST_N(RST_N), .BIT_TICK(BIT_TICK),
        .ABORT(ABORT), .STUFF_EN(STUFF_EN),
        .IN_VALID(IN_VALID), .IN_BIT(IN_BIT),
        .IN_READY(IN_READY), .TX_BIT(TX_BIT),
        .STUFF_ACTIVE(STUFF_ACTIVE), .UNDERRUN(UNDERRUN)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string nm, input logic act,
                       input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b want %b", nm, act, exp);
        end
    endtask

    function automatic vec_t mk(
        input logic en, vld, bt, ab, rdy, tx, st, un);
        vec_t v;
        v.en = en; v.vld = vld; v.bt = bt; v.ab = ab;
        v.rdy = rdy; v.tx = tx; v.st = st; v.un = un;
        return v;
    endfunction

    task automatic do_tick(input vec_t v, input string nm);
        @(negedge CLK);
        STUFF_EN = v.en; IN_VALID = v.vld;
        IN_BIT = v.bt; ABORT = v.ab; BIT_TICK = 1'b1;
        #1 chk({nm, " ready"}, IN_READY, v.rdy);
        @(posedge CLK);
        #1;
        chk({nm, " tx"}, TX_BIT, v.tx);
        chk({nm, " stuff"}, STUFF_ACTIVE, v.st);
        chk({nm, " underrun"}, UNDERRUN, v.un);
        @(negedge CLK);
        BIT_TICK = 1'b0; ABORT = 1'b0;
        #1 chk({nm, " idle ready"}, IN_READY, 1'b0);
        @(posedge CLK);
        #1;
        chk({nm, " hold tx"}, TX_BIT, v.tx);
        chk({nm, " hold stuff"}, STUFF_ACTIVE, v.st);
        chk({nm, " underrun width"}, UNDERRUN, 1'b0);
    endtask

    initial begin
        // fields: en vld bit abort | rdy tx stuff under
        // idle after reset, unstuffed region, nothing offered
        repeat (3) vt.push_back(mk(0,0,0,0, 1,1,0,0));
        // stuffing chain 0000011110
        repeat (5) vt.push_back(mk(1,1,0,0, 1,0,0,0));
        vt.push_back(mk(1,1,1,0, 0,1,1,0));
        repeat (4) vt.push_back(mk(1,1,1,0, 1,1,0,0));
        vt.push_back(mk(1,1,0,0, 0,0,1,0));
        vt.push_back(mk(1,1,0,0, 1,0,0,0));
        vt.push_back(mk(1,0,0,1, 0,1,0,0));
        // unstuffed: seven 1s
        repeat (7) vt.push_back(mk(0,1,1,0, 1,1,0,0));
        vt.push_back(mk(0,0,0,1, 0,1,0,0));
        // region boundary: stuff bit survives STUFF_EN drop
        repeat (5) vt.push_back(mk(1,1,1,0, 1,1,0,0));
        vt.push_back(mk(0,1,1,0, 0,0,1,0));
        vt.push_back(mk(0,1,1,0, 1,1,0,0));
        vt.push_back(mk(0,0,0,1, 0,1,0,0));
        // abort breaks the run, then underrun
        repeat (3) vt.push_back(mk(1,1,0,0, 1,0,0,0));
        vt.push_back(mk(1,1,0,1, 0,1,0,0));
        repeat (2) vt.push_back(mk(1,1,0,0, 1,0,0,0));
        vt.push_back(mk(1,1,1,0, 1,1,0,0));
        vt.push_back(mk(1,1,0,0, 1,0,0,0));
        vt.push_back(mk(1,0,0,0, 1,1,0,1));
        vt.push_back(mk(0,0,0,0, 1,1,0,0));

        repeat (2) @(posedge CLK);
        #1;
        chk("reset tx", TX_BIT, 1'b1);
        chk("reset stuff", STUFF_ACTIVE, 1'b0);
        chk("reset underrun", UNDERRUN, 1'b0);
        chk("reset ready", IN_READY, 1'b0);
        @(negedge CLK);
        RST_N = 1'b1;

        foreach (vt[i])
            do_tick(vt[i], $sformatf("vec%0d", i));

        // ABORT on a non-tick cycle drops a pending stuff bit
        repeat (5)
            do_tick(mk(1,1,0,0, 1,0,0,0), "pre-abort");
        @(negedge CLK);
        ABORT = 1'b1;
        @(posedge CLK);
        #1 chk("idle abort tx", TX_BIT, 1'b1);
        @(negedge CLK);
        ABORT = 1'b0;
        do_tick(mk(1,1,0,0, 1,0,0,0), "post-abort");
        do_tick(mk(0,0,0,1, 0,1,0,0), "clr");

        // async reset with a stuff bit pending
        repeat (5)
            do_tick(mk(1,1,0,0, 1,0,0,0), "pre-rst");
        #2 RST_N = 1'b0;
        #1;
        chk("midrst tx", TX_BIT, 1'b1);
        chk("midrst stuff", STUFF_ACTIVE, 1'b0);
        @(negedge CLK);
        RST_N = 1'b1;
        do_tick(mk(1,1,0,0, 1,0,0,0), "post-rst");
        do_tick(mk(1,1,0,0, 1,0,0,0), "post-rst2");

        $display("Result: errors=%0d of %0d checks",
                 errors, checks);
        $finish;
    end

endmodule
